// File: rtl/serial_word_receiver.sv
// ---------------------------------------------------------------------------
// serial_word_receiver
//
// Receive end of the parallel-load shift-register serial link. Bits arrive on
// SIN, qualified by SIN_VALID; SYNC marks the first bit of each word. N bits
// are gathered MSB-first or LSB-first (chosen by DIR at word start) and the
// finished word is parked in a valid/ready holding register for the parallel
// consumer. Dropped words and early SYNCs raise sticky error flags.
//
// Ports
//   CLK         in   system clock, rising edge
//   RST         in   synchronous active-high reset
//   SIN         in   serial data bit
//   SIN_VALID   in   SIN/SYNC are sampled only when high
//   SYNC        in   first bit of a word
//   DIR         in   0 = MSB-first (shift left), 1 = LSB-first (shift right)
//   DATA_READY  in   consumer takes DATA_OUT when high with DATA_VALID
//   CLR_ERR     in   clears OVERRUN and FRAME_ERR
//   DATA_OUT    out  last completed word
//   DATA_VALID  out  DATA_OUT holds an unconsumed word
//   BUSY        out  a word is partially received
//   OVERRUN     out  sticky: completed word dropped, holding register full
//   FRAME_ERR   out  sticky: SYNC arrived in the middle of a word
//
// State table
//   state | meaning
//   IDLE  | waiting for a SYNC-marked bit; unframed bits are ignored
//   RECV  | 1..N-1 bits of the current word collected
// ---------------------------------------------------------------------------
module serial_word_receiver #(
    parameter int N = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         SIN,
    input  logic         SIN_VALID,
    input  logic         SYNC,
    input  logic         DIR,
    input  logic         DATA_READY,
    input  logic         CLR_ERR,
    output logic [N-1:0] DATA_OUT,
    output logic         DATA_VALID,
    output logic         BUSY,
    output logic         OVERRUN,
    output logic         FRAME_ERR
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t          state;
    logic            dir_q;
    logic [N-1:0]    sr;
    logic [CW-1:0]   count;

    logic            start;
    logic            accept;
    logic            dir_eff;
    logic [N-1:0]    sr_base;
    logic [N-1:0]    sr_next;
    logic [CW-1:0]   count_next;
    logic            complete;
    logic            load;
    logic            overrun_set;
    logic            frame_set;

    // A framed bit starts a word from either state; in RECV it also throws
    // away the partial word, so the shift starts from an empty register.
    assign start   = SIN_VALID && SYNC;
    assign accept  = SIN_VALID && (SYNC || (state == RECV));
    assign dir_eff = start ? DIR : dir_q;
    assign sr_base = start ? '0 : sr;

    always_comb begin
        sr_next = sr_base;
        if (dir_eff) begin
            sr_next = {SIN, sr_base[N-1:1]};
        end else begin
            sr_next = {sr_base[N-2:0], SIN};
        end
    end

    assign count_next = start ? CW'(1) : count + CW'(1);

    // The N-th bit is judged on the edge that samples it, using the
    // combinational next-word, so DATA_VALID rises one cycle later.
    assign complete    = accept && (count_next == CW'(N));
    assign load        = !DATA_VALID || DATA_READY;
    assign overrun_set = complete && !load;
    assign frame_set   = start && (state == RECV);

    assign BUSY = (state == RECV);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            dir_q      <= 1'b0;
            sr         <= '0;
            count      <= '0;
            DATA_OUT   <= '0;
            DATA_VALID <= 1'b0;
            OVERRUN    <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            if (accept) begin
                if (start) begin
                    dir_q <= DIR;
                end
                if (complete) begin
                    state <= IDLE;
                    count <= '0;
                    sr    <= '0;
                end else begin
                    state <= RECV;
                    count <= count_next;
                    sr    <= sr_next;
                end
            end

            if (complete && load) begin
                DATA_OUT   <= sr_next;
                DATA_VALID <= 1'b1;
            end else if (!complete && DATA_VALID && DATA_READY) begin
                DATA_VALID <= 1'b0;
            end

            // A new error on the clearing edge still leaves the flag set.
            OVERRUN   <= overrun_set || (OVERRUN && !CLR_ERR);
            FRAME_ERR <= frame_set || (FRAME_ERR && !CLR_ERR);
        end
    end

endmodule

// File: tb/tb_serial_word_receiver.sv
module tb_serial_word_receiver;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sin = 1'b0;
    logic         sin_valid = 1'b0;
    logic         sync = 1'b0;
    logic         dir = 1'b0;
    logic         data_ready = 1'b0;
    logic         clr_err = 1'b0;
    logic [N-1:0] data_out;
    logic         data_valid;
    logic         busy;
    logic         overrun;
    logic         frame_err;

    int checks = 0;
    int failures = 0;

    // reference model: word under construction kept as a plain list of bits
    bit           m_busy = 1'b0;
    bit           m_dir = 1'b0;
    bit           m_bits[$];
    logic [N-1:0] m_out = '0;
    bit           m_valid = 1'b0;
    bit           m_ov = 1'b0;
    bit           m_fe = 1'b0;

    serial_word_receiver #(.N(N)) dut (
        .CLK        (clk),
        .RST        (rst),
        .SIN        (sin),
        .SIN_VALID  (sin_valid),
        .SYNC       (sync),
        .DIR        (dir),
        .DATA_READY (data_ready),
        .CLR_ERR    (clr_err),
        .DATA_OUT   (data_out),
        .DATA_VALID (data_valid),
        .BUSY       (busy),
        .OVERRUN    (overrun),
        .FRAME_ERR  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] w;
        bit done;
        bit ov_set;
        bit fe_set;
        done = 1'b0;
        ov_set = 1'b0;
        fe_set = 1'b0;
        w = '0;
        if (rst) begin
            m_busy = 1'b0;
            m_dir = 1'b0;
            m_bits.delete();
            m_out = '0;
            m_valid = 1'b0;
            m_ov = 1'b0;
            m_fe = 1'b0;
            return;
        end
        if (sin_valid) begin
            if (sync) begin
                if (m_busy) fe_set = 1'b1;
                m_bits.delete();
                m_dir = dir;
                m_bits.push_back(sin);
                m_busy = 1'b1;
            end else if (m_busy) begin
                m_bits.push_back(sin);
            end
            if (m_busy && m_bits.size() == N) begin
                for (int i = 0; i < N; i++) begin
                    if (m_dir) w[i] = m_bits[i];
                    else       w[N-1-i] = m_bits[i];
                end
                done = 1'b1;
                m_busy = 1'b0;
                m_bits.delete();
            end
        end
        if (done) begin
            if (!m_valid || data_ready) begin
                m_out = w;
                m_valid = 1'b1;
            end else begin
                ov_set = 1'b1;
            end
        end else if (m_valid && data_ready) begin
            m_valid = 1'b0;
        end
        m_ov = ov_set || (m_ov && !clr_err);
        m_fe = fe_set || (m_fe && !clr_err);
    endtask

    // one clock with the currently driven inputs; outputs checked mid-cycle
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk_val("data_out", 32'(data_out), 32'(m_out));
        chk_val("data_valid", 32'(data_valid), 32'(m_valid));
        chk_val("busy", 32'(busy), 32'(m_busy));
        chk_val("overrun", 32'(overrun), 32'(m_ov));
        chk_val("frame_err", 32'(frame_err), 32'(m_fe));
    endtask

    task automatic send_bits(input logic [N-1:0] w, input logic d, input int nbits,
                             input bit gaps, input bit ready_on_last);
        for (int i = 0; i < nbits; i++) begin
            if (gaps && i > 0 && ($urandom_range(1, 0) == 1)) begin
                sin_valid = 1'b0;
                sin = 1'($urandom);
                sync = 1'($urandom);
                dir = 1'($urandom);
                step();
            end
            sin_valid = 1'b1;
            sync = (i == 0);
            dir = (i == 0) ? d : 1'($urandom);
            sin = d ? w[i] : w[N-1-i];
            if (ready_on_last && i == nbits - 1) data_ready = 1'b1;
            step();
            if (ready_on_last && i == nbits - 1) data_ready = 1'b0;
        end
        sin_valid = 1'b0;
        sync = 1'b0;
    endtask

    task automatic drain();
        data_ready = 1'b1;
        step();
        data_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
    endtask

    initial begin
        // reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk_val("rst_data_out", 32'(data_out), 32'h0);
        chk_val("rst_valid", 32'(data_valid), 32'h0);
        chk_val("rst_busy", 32'(busy), 32'h0);

        // MSB-first, held until consumed
        send_bits(8'hA5, 1'b0, N, 1'b0, 1'b0);
        chk_val("msb_valid", 32'(data_valid), 32'h1);
        chk_val("msb_word", 32'(data_out), 32'hA5);
        step();
        chk_val("msb_hold", 32'(data_out), 32'hA5);
        drain();
        chk_val("msb_taken_valid", 32'(data_valid), 32'h0);
        chk_val("msb_taken_word", 32'(data_out), 32'hA5);

        // LSB-first with gaps and DIR wiggling mid-word
        send_bits(8'h3C, 1'b1, N, 1'b1, 1'b0);
        chk_val("lsb_word", 32'(data_out), 32'h3C);
        chk_val("lsb_idle", 32'(busy), 32'h0);
        drain();

        // overrun
        send_bits(8'h11, 1'b0, N, 1'b0, 1'b0);
        send_bits(8'h22, 1'b0, N, 1'b0, 1'b0);
        chk_val("ovr_word", 32'(data_out), 32'h11);
        chk_val("ovr_flag", 32'(overrun), 32'h1);
        pulse_clr();
        chk_val("ovr_cleared", 32'(overrun), 32'h0);
        drain();
        send_bits(8'h11, 1'b0, N, 1'b0, 1'b0);
        send_bits(8'h22, 1'b0, N, 1'b0, 1'b1);
        chk_val("ovr_ready_word", 32'(data_out), 32'h22);
        chk_val("ovr_ready_flag", 32'(overrun), 32'h0);
        drain();

        // resync
        send_bits(8'h00, 1'b0, 3, 1'b0, 1'b0);
        chk_val("resync_busy", 32'(busy), 32'h1);
        send_bits(8'hFF, 1'b0, N, 1'b0, 1'b0);
        chk_val("resync_fe", 32'(frame_err), 32'h1);
        chk_val("resync_word", 32'(data_out), 32'hFF);
        drain();
        pulse_clr();

        // reset mid-word
        send_bits(8'h5A, 1'b1, 5, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_val("mid_rst_out", 32'(data_out), 32'h0);
        chk_val("mid_rst_busy", 32'(busy), 32'h0);
        chk_val("mid_rst_valid", 32'(data_valid), 32'h0);
        send_bits(8'h81, 1'b0, N, 1'b0, 1'b0);
        chk_val("post_rst_word", 32'(data_out), 32'h81);

        // error clear, and set-wins on the clearing edge
        send_bits(8'h42, 1'b0, N, 1'b0, 1'b0);
        chk_val("clr_pre_ov", 32'(overrun), 32'h1);
        pulse_clr();
        chk_val("clr_ov", 32'(overrun), 32'h0);
        send_bits(8'h00, 1'b0, 3, 1'b0, 1'b0);
        clr_err = 1'b1;
        sin_valid = 1'b1;
        sync = 1'b1;
        sin = 1'b1;
        step();
        clr_err = 1'b0;
        sin_valid = 1'b0;
        sync = 1'b0;
        chk_val("clr_vs_resync_fe", 32'(frame_err), 32'h1);

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(199, 0) == 0);
            sin_valid = ($urandom_range(3, 0) != 0);
            sync = ($urandom_range(9, 0) == 0);
            sin = 1'($urandom);
            dir = 1'($urandom);
            data_ready = ($urandom_range(2, 0) == 0);
            clr_err = ($urandom_range(29, 0) == 0);
            step();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
- Deserializing receive end for the team's parallel-load shift-register transmitter.
- Collects N serial bits, MSB-first (left shift) or LSB-first (right shift), into a parallel word.
- Presents each completed word on a valid/ready holding register and flags overrun and framing errors.
- Sits between a serial link input and the parallel datapath consumer.

Parameters:
- N, 8, word width in bits; legal range N >= 2.

Ports:
- CLK  input  1  system clock; all logic is on the rising edge.
- RST  input  1  synchronous, active-high reset.
- SIN  input  1  serial data bit.
- SIN_VALID  input  1  SIN is sampled on this edge only when high.
- SYNC  input  1  first-bit-of-word marker; qualified by SIN_VALID.
- DIR  input  1  0 = MSB-first (shift left), 1 = LSB-first (shift right); sampled at word start only.
- DATA_READY  input  1  consumer accepts DATA_OUT when high together with DATA_VALID.
- CLR_ERR  input  1  clears the sticky error flags.
- DATA_OUT  output  N  last completed word (holding register).
- DATA_VALID  output  1  DATA_OUT holds an unconsumed word.
- BUSY  output  1  high while a word is partially received (state RECV).
- OVERRUN  output  1  sticky: a completed word was dropped because the holding register was full.
- FRAME_ERR  output  1  sticky: SYNC arrived before the current word completed.

Behaviour:
- Reset: RST=1 has priority over every other input. On reset: DATA_OUT=0, DATA_VALID=0, BUSY=0, OVERRUN=0, FRAME_ERR=0, shift register=0, bit count=0, state=IDLE. Any partial word is discarded.
- State machine has two states, IDLE and RECV.
- IDLE:
  - SIN_VALID=1 and SYNC=1: latch DIR into dir_q, shift SIN in, set count=1, go to RECV.
  - SIN_VALID=1 and SYNC=0: bit ignored, stay in IDLE.
- RECV:
  - SIN_VALID=0: hold all state.
  - SIN_VALID=1 and SYNC=0: shift SIN in, count+1.
  - SIN_VALID=1 and SYNC=1: resync. Discard the partial word, set FRAME_ERR, re-latch DIR, shift SIN in as bit 1, set count=1, stay in RECV.
- Shift rule:
  - dir_q=0: sr <= {sr[N-2:0], SIN}; the first bit lands in DATA_OUT[N-1].
  - dir_q=1: sr <= {SIN, sr[N-1:1]}; the first bit lands in DATA_OUT[0].
  - Changes on DIR mid-word have no effect.
- Completion (the edge that samples the N-th bit):
  - The next-sr value is formed combinationally and the word is evaluated on that same edge; there are no extra cycles.
  - If DATA_VALID=0, or DATA_VALID=1 with DATA_READY=1 on this edge: DATA_OUT <= word and DATA_VALID=1 after the edge.
  - Otherwise: the word is dropped, OVERRUN is set, and DATA_OUT/DATA_VALID are unchanged.
  - After completion, state returns to IDLE, count=0 and BUSY=0.
  - Latency: DATA_VALID is high in the cycle immediately after the N-th bit's edge.
- Handshake:
  - DATA_VALID=1 and DATA_READY=0: DATA_OUT is held stable.
  - DATA_VALID=1 and DATA_READY=1 with no word completing: DATA_VALID clears on this edge; DATA_OUT keeps its value.
- Error flags:
  - CLR_ERR=1 clears OVERRUN and FRAME_ERR.
  - If a new error condition occurs on the same edge as CLR_ERR, the flag ends up set (set wins).
- Bit counter width is clog2(N)+1; the count never exceeds N.
- BUSY = (state == RECV).

Test Plan (N=8):
- MSB-first: DIR=0; SYNC with the first bit; 8 consecutive bits of 0xA5; DATA_READY=0 -> DATA_VALID=1 the cycle after the 8th edge, DATA_OUT=8'hA5 held. Then DATA_READY=1 for one cycle -> DATA_VALID=0, DATA_OUT stays 8'hA5.
- LSB-first with gaps: DIR=1 at SYNC; send 0x3C LSB-first with SIN_VALID=0 gaps; toggle DIR at bit 4 -> DATA_OUT=8'h3C; BUSY=1 throughout the word.
- Overrun:
  - DATA_READY=0; send 0x11 then 0x22 -> DATA_OUT=8'h11, OVERRUN=1.
  - Repeat with DATA_READY=1 on the 0x22 completion edge -> DATA_OUT=8'h22, OVERRUN stays 0 (after CLR_ERR).
- Resync: send 3 bits, then SYNC with the first bit of 0xFF, followed by its 7 bits -> FRAME_ERR=1, DATA_OUT=8'hFF, no word from the partial bits.
- Reset mid-word: RST=1 for one cycle after 5 bits -> all outputs 0, BUSY=0; the next framed word 0x81 is received as 8'h81.
- Error clear: with OVERRUN=1, pulse CLR_ERR -> 0. CLR_ERR on the same edge as a new resync -> FRAME_ERR=1.
